shift_seq_ctrl: RTL and testbench

- Sequencing controller for an external N-bit universal shift register (ctrl 00 hold, 01 shift left with serial-in d[0], 10 shift right with serial-in d[N-1], 11 parallel load).
- Accepts one shift command at a time on a valid/ready interface, then drives the register's ctrl/d inputs: load, then the requested number of shifts, then hold.
- Returns the final register contents with a one-cycle done pulse and exposes the shifted-out serial bit stream.

---
 rtl/shift_seq_ctrl.sv | 109 ++++++++++
 tb/tb_shift_seq_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// Sequencing controller for an external N-bit universal shift register:
// accepts one command, then drives load, N-saturated shifts and hold, and returns the result.
module shift_seq_ctrl #(
    parameter int N  = 8,
    parameter int CW = $clog2(N+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_dir,
    input  logic          cmd_fill,
    input  logic [N-1:0]  cmd_data,
    input  logic [CW-1:0] cmd_count,
    output logic [1:0]    sr_ctrl,
    output logic [N-1:0]  sr_d,
    input  logic [N-1:0]  sr_q,
    output logic          ser_out,
    output logic          ser_valid,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  result
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FINISH} state_t;

    localparam logic [1:0]    CTRL_HOLD  = 2'b00;
    localparam logic [1:0]    CTRL_LEFT  = 2'b01;
    localparam logic [1:0]    CTRL_RIGHT = 2'b10;
    localparam logic [1:0]    CTRL_LOAD  = 2'b11;
    localparam logic [CW-1:0] COUNT_MAX  = CW'(N);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    state_t        state, state_nxt;
    logic          dir_r, fill_r;
    logic [N-1:0]  data_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_sat;

    // Shifting more than N times cannot change the outcome, so clamp at N.
    assign count_sat = (cmd_count > COUNT_MAX) ? COUNT_MAX : cmd_count;
    assign busy      = (state != IDLE);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            dir_r   <= 1'b0;
            fill_r  <= 1'b0;
            data_r  <= '0;
            count_r <= '0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        dir_r   <= cmd_dir;
                        fill_r  <= cmd_fill;
                        data_r  <= cmd_data;
                        count_r <= count_sat;
                    end
                end
                SHIFT:   count_r <= count_r - COUNT_ONE;
                FINISH: begin
                    result <= sr_q;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        sr_ctrl   = CTRL_HOLD;
        sr_d      = '0;
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = LOAD;
            end
            LOAD: begin
                sr_ctrl   = CTRL_LOAD;
                sr_d      = data_r;
                state_nxt = (count_r != '0) ? SHIFT : FINISH;
            end
            SHIFT: begin
                sr_ctrl   = dir_r ? CTRL_RIGHT : CTRL_LEFT;
                sr_d      = {N{fill_r}};
                // The bit at the far end is the one about to fall out this cycle.
                ser_out   = dir_r ? sr_q[0] : sr_q[N-1];
                ser_valid = 1'b1;
                if (count_r == COUNT_ONE) state_nxt = FINISH;
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural universal shift register
// attached; cycle 0 is the handshake cycle of each command.
module tb_shift_seq_ctrl;

    localparam int N  = 8;
    localparam int CW = $clog2(N+1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid, cmd_ready, cmd_dir, cmd_fill;
    logic [N-1:0]  cmd_data;
    logic [CW-1:0] cmd_count;
    logic [1:0]    sr_ctrl;
    logic [N-1:0]  sr_d, sr_q, result;
    logic          ser_out, ser_valid, busy, done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0]   ctrl_tr[$];
    logic         ser_tr[$];
    int           done_cyc;
    logic [N-1:0] res, d_load, d_shift;

    shift_seq_ctrl #(.N(N), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_fill(cmd_fill),
        .cmd_data(cmd_data), .cmd_count(cmd_count),
        .sr_ctrl(sr_ctrl), .sr_d(sr_d), .sr_q(sr_q),
        .ser_out(ser_out), .ser_valid(ser_valid),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // External universal shift register.
    always_ff @(posedge clk) begin
        if (rst) sr_q <= '0;
        else begin
            case (sr_ctrl)
                2'b01:   sr_q <= {sr_q[N-2:0], sr_d[0]};
                2'b10:   sr_q <= {sr_d[N-1], sr_q[N-1:1]};
                2'b11:   sr_q <= sr_d;
                default: sr_q <= sr_q;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack_ctrl(input int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n && i < ctrl_tr.size(); i++) v = {v[29:0], ctrl_tr[i]};
        return v;
    endfunction

    function automatic logic [31:0] pack_ser(input int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n && i < ser_tr.size(); i++) v = {v[30:0], ser_tr[i]};
        return v;
    endfunction

    // Issues one command in the current cycle and traces until done (bounded).
    task automatic run_cmd(input string name, input logic [N-1:0] data, input logic dir,
                           input logic fill, input logic [CW-1:0] cnt);
        ctrl_tr.delete();
        ser_tr.delete();
        done_cyc  = -1;
        res       = 'x;
        cmd_valid = 1'b1;
        cmd_data  = data;
        cmd_dir   = dir;
        cmd_fill  = fill;
        cmd_count = cnt;
        check({name, "_ready_c0"}, 32'(cmd_ready), 32'd1);
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            tick();
            if (c == 1) begin
                cmd_valid = 1'b0;
                cmd_data  = ~data;
                cmd_dir   = ~dir;
                cmd_fill  = ~fill;
                d_load    = sr_d;
            end
            if (c == 2) d_shift = sr_d;
            ctrl_tr.push_back(sr_ctrl);
            if (ser_valid) ser_tr.push_back(ser_out);
            if (done) begin
                done_cyc = c;
                res      = result;
            end
        end
        check({name, "_done_seen"}, 32'(done_cyc >= 0), 32'd1);
    endtask

    initial begin
        int accept_cyc, done_a, done_b, nshift;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_fill  = 1'b0;
        cmd_data  = '0;
        cmd_count = '0;
        repeat (3) tick();

        check("rst_sr_ctrl", 32'(sr_ctrl), 32'd0);
        check("rst_sr_d", 32'(sr_d), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_ser_valid", 32'(ser_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;
        tick();

        // Left shift, fill 0: 0xAA -> 0x54 -> 0xA8 -> 0x50.
        run_cmd("t1", 8'hAA, 1'b0, 1'b0, 4'd3);
        check("t1_done_cyc", 32'(done_cyc), 32'd6);
        check("t1_result", 32'(res), 32'h50);
        check("t1_ctrl_seq", pack_ctrl(5), 32'b11_01_01_01_00);
        check("t1_nser", 32'(ser_tr.size()), 32'd3);
        check("t1_ser_seq", pack_ser(3), 32'b101);
        check("t1_load_d", 32'(d_load), 32'hAA);
        check("t1_shift_d", 32'(d_shift), 32'h00);
        check("t1_busy_in_done", 32'(busy), 32'd0);
        tick();
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_result_hold", 32'(result), 32'h50);

        // Right shift, fill 1: 0xAA -> 0xD5 -> 0xEA -> 0xF5.
        run_cmd("t2", 8'hAA, 1'b1, 1'b1, 4'd3);
        check("t2_done_cyc", 32'(done_cyc), 32'd6);
        check("t2_result", 32'(res), 32'hF5);
        check("t2_ctrl_seq", pack_ctrl(5), 32'b11_10_10_10_00);
        check("t2_ser_seq", pack_ser(3), 32'b010);
        check("t2_shift_d", 32'(d_shift), 32'hFF);
        tick();

        // Zero count: load then straight to FINISH.
        run_cmd("t3", 8'h3C, 1'b0, 1'b0, 4'd0);
        check("t3_done_cyc", 32'(done_cyc), 32'd3);
        check("t3_result", 32'(res), 32'h3C);
        check("t3_nser", 32'(ser_tr.size()), 32'd0);
        check("t3_ctrl_seq", pack_ctrl(2), 32'b11_00);
        tick();

        // Saturation (12 -> 8 shifts) with a second command held during busy.
        cmd_valid  = 1'b1;
        cmd_data   = 8'h00;
        cmd_dir    = 1'b0;
        cmd_fill   = 1'b1;
        cmd_count  = 4'd12;
        accept_cyc = -1;
        done_a     = -1;
        nshift     = 0;
        res        = 'x;
        for (int c = 1; c <= 40 && accept_cyc < 0; c++) begin
            tick();
            if (c == 1) begin
                cmd_data  = 8'h3C;
                cmd_dir   = 1'b1;
                cmd_fill  = 1'b1;
                cmd_count = 4'd0;
            end
            nshift += int'(ser_valid);
            if (done && done_a < 0) begin
                done_a = c;
                res    = result;
            end
            if (cmd_ready) accept_cyc = c;
        end
        check("t4_accept_cyc", 32'(accept_cyc), 32'd11);
        check("t4_done_cyc", 32'(done_a), 32'd11);
        check("t4_nshift", 32'(nshift), 32'd8);
        check("t4_result", 32'(res), 32'hFF);
        done_b = -1;
        for (int c = 12; c <= 40 && done_b < 0; c++) begin
            tick();
            if (c == 12) cmd_valid = 1'b0;
            if (c == 13) check("t4_result_hold", 32'(result), 32'hFF);
            if (done) begin
                done_b = c;
                res    = result;
            end
        end
        check("t4b_done_cyc", 32'(done_b), 32'd14);
        check("t4b_result", 32'(res), 32'h3C);
        tick();

        // Reset during the 2nd SHIFT cycle of a count=5 command.
        cmd_valid = 1'b1;
        cmd_data  = 8'h0F;
        cmd_dir   = 1'b0;
        cmd_fill  = 1'b0;
        cmd_count = 4'd5;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("t5_in_shift", 32'(ser_valid), 32'd1);
        rst = 1'b1;
        tick();
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_ready", 32'(cmd_ready), 32'd1);
        check("t5_sr_ctrl", 32'(sr_ctrl), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_result", 32'(result), 32'd0);
        check("t5_ser_valid", 32'(ser_valid), 32'd0);
        rst = 1'b0;
        tick();

        // Fresh command after reset: 0x81 right by 1, fill 0 -> 0x40, bit out 1.
        run_cmd("t6", 8'h81, 1'b1, 1'b0, 4'd1);
        check("t6_done_cyc", 32'(done_cyc), 32'd4);
        check("t6_result", 32'(res), 32'h40);
        check("t6_ser_seq", pack_ser(1), 32'b1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
